// File: rtl/branch_resolver.sv
// Purpose: multi-cycle RV32I conditional-branch resolver (BEQ/BNE/BLT/BGE/BLTU/BGEU) with taken counter.
// Latency: result valid 2 clock edges after the request is accepted; one request in flight at a time.
// Backpressure: in_ready only in IDLE; result and outputs are held in DONE until out_ready.
// Ports: clk/rst_n (sync, active-low); in_valid/in_ready + in_funct3/in_rs1/in_rs2/in_pc/in_imm request;
//        out_valid/out_ready + out_taken/out_target/out_illegal result; taken_count = delivered taken results.
module branch_resolver #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_funct3,
   input  logic [XLEN-1:0]  in_rs1,
   input  logic [XLEN-1:0]  in_rs2,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_taken,
   output logic [XLEN-1:0]  out_target,
   output logic             out_illegal,
   output logic [CNT_W-1:0] taken_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [XLEN-1:0]   rs1_q, rs1_d;
   logic [XLEN-1:0]   rs2_q, rs2_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   imm_q, imm_d;
   logic              taken_q, taken_d;
   logic [XLEN-1:0]   target_q, target_d;
   logic              illegal_q, illegal_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Shared compare datapath: one extra bit on the subtract gives the unsigned borrow.
   logic [XLEN:0]     diff;
   logic              zero, lt, ltu;
   logic              cmp_taken, cmp_illegal;

   always_comb begin
      diff = {1'b0, rs1_q} - {1'b0, rs2_q};
      zero = (diff[XLEN-1:0] == '0);
      ltu  = diff[XLEN];
      // Differing signs decide signed order directly; equal signs cannot overflow the subtract.
      lt   = (rs1_q[XLEN-1] != rs2_q[XLEN-1]) ? rs1_q[XLEN-1] : diff[XLEN-1];

      cmp_taken   = 1'b0;
      cmp_illegal = 1'b0;
      case (funct3_q)
         3'b000:  cmp_taken = zero;
         3'b001:  cmp_taken = !zero;
         3'b100:  cmp_taken = lt;
         3'b101:  cmp_taken = !lt;
         3'b110:  cmp_taken = ltu;
         3'b111:  cmp_taken = !ltu;
         default: cmp_illegal = 1'b1;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      funct3_d  = funct3_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      pc_d      = pc_q;
      imm_d     = imm_q;
      taken_d   = taken_q;
      target_d  = target_q;
      illegal_d = illegal_q;
      cnt_d     = cnt_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               funct3_d = in_funct3;
               rs1_d    = in_rs1;
               rs2_d    = in_rs2;
               pc_d     = in_pc;
               imm_d    = in_imm;
               state_d  = CALC;
            end
         end
         CALC: begin
            taken_d   = cmp_taken;
            illegal_d = cmp_illegal;
            target_d  = pc_q + imm_q;
            state_d   = DONE;
         end
         DONE: begin
            if (out_ready) begin
               // Illegal results always carry taken=0, so they never count.
               if (taken_q) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         funct3_q  <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         pc_q      <= '0;
         imm_q     <= '0;
         taken_q   <= 1'b0;
         target_q  <= '0;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         funct3_q  <= funct3_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         pc_q      <= pc_d;
         imm_q     <= imm_d;
         taken_q   <= taken_d;
         target_q  <= target_d;
         illegal_q <= illegal_d;
         cnt_q     <= cnt_d;
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign out_taken   = taken_q;
   assign out_target  = target_q;
   assign out_illegal = illegal_q;
   assign taken_count = cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: expected results are queued on accept and checked on delivery.
// A narrow counter width keeps the counter-wrap case short.
module tb_branch_resolver;
   localparam int XLEN  = 32;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_funct3;
   logic [XLEN-1:0]  in_rs1, in_rs2, in_pc, in_imm;
   logic             out_valid;
   logic             out_ready;
   logic             out_taken;
   logic [XLEN-1:0]  out_target;
   logic             out_illegal;
   logic [CNT_W-1:0] taken_count;

   typedef struct packed {
      logic            taken;
      logic [XLEN-1:0] target;
      logic            illegal;
   } exp_t;

   exp_t             sb[$];
   int               checks = 0;
   int               errors = 0;
   logic [CNT_W-1:0] exp_cnt = '0;

   branch_resolver #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
      .out_target(out_target), .out_illegal(out_illegal), .taken_count(taken_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference decision written with native signed/unsigned comparisons.
   function automatic exp_t model(input logic [2:0] f3, input logic [XLEN-1:0] a, b, pc, imm);
      exp_t e;
      e.target  = pc + imm;
      e.illegal = 1'b0;
      case (f3)
         3'b000:  e.taken = (a == b);
         3'b001:  e.taken = (a != b);
         3'b100:  e.taken = ($signed(a) <  $signed(b));
         3'b101:  e.taken = ($signed(a) >= $signed(b));
         3'b110:  e.taken = (a <  b);
         3'b111:  e.taken = (a >= b);
         default: begin e.taken = 1'b0; e.illegal = 1'b1; end
      endcase
      return e;
   endfunction

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [2:0] f3, input logic [XLEN-1:0] a, b, pc, imm);
      int n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         chk("send_timeout", 64'(in_ready), 64'd1);
         return;
      end
      in_valid = 1'b1; in_funct3 = f3; in_rs1 = a; in_rs2 = b; in_pc = pc; in_imm = imm;
      @(posedge clk); #1;
      in_valid = 1'b0;
      sb.push_back(model(f3, a, b, pc, imm));
   endtask

   // Waits for a result, holds out_ready low for 'hold' cycles while poking in_valid, then accepts.
   task automatic recv(input string tag, input int hold);
      int   n = 0;
      exp_t e, snap;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) begin
         chk({tag, "_timeout"}, 64'(out_valid), 64'd1);
         return;
      end
      if (sb.size() == 0) begin
         chk({tag, "_unexpected"}, 64'(sb.size()), 64'd1);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_taken"},   64'(out_taken),   64'(e.taken));
      chk({tag, "_target"},  64'(out_target),  64'(e.target));
      chk({tag, "_illegal"}, 64'(out_illegal), 64'(e.illegal));
      snap = '{out_taken, out_target, out_illegal};
      for (int i = 0; i < hold; i++) begin
         in_valid = (i % 2 == 0); in_funct3 = 3'b001;
         in_rs1 = $urandom; in_rs2 = $urandom; in_pc = $urandom; in_imm = $urandom;
         @(negedge clk);
         chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
         chk({tag, "_hold_rdy"},   64'(in_ready),  64'd0);
         chk({tag, "_hold_res"},   64'({out_taken, out_target, out_illegal}), 64'(snap));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (e.taken) exp_cnt = exp_cnt + 1'b1;
      chk({tag, "_vld_drop"}, 64'(out_valid),   64'd0);
      chk({tag, "_count"},    64'(taken_count), 64'(exp_cnt));
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_funct3 = '0; in_rs1 = '0; in_rs2 = '0; in_pc = '0; in_imm = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_in_ready", 64'(in_ready),    64'd1);
      chk("rst_out_vld",  64'(out_valid),   64'd0);
      chk("rst_taken",    64'(out_taken),   64'd0);
      chk("rst_target",   64'(out_target),  64'd0);
      chk("rst_illegal",  64'(out_illegal), 64'd0);
      chk("rst_count",    64'(taken_count), 64'd0);

      // 1: BEQ equal operands, latency of two edges after accept.
      send(3'b000, 32'h0000_1234, 32'h0000_1234, 32'h100, 32'h20);
      chk("t1_rdy_calc", 64'(in_ready), 64'd0);
      @(negedge clk);
      chk("t1_lat_n",  64'(out_valid), 64'd0);
      @(negedge clk);
      chk("t1_lat_n1", 64'(out_valid), 64'd1);
      chk("t1_tgt_direct", 64'(out_target), 64'h120);
      chk("t1_tkn_direct", 64'(out_taken),  64'd1);
      recv("t1", 0);

      // 2: signed vs unsigned ordering of -1 and 1, plus BGE.
      send(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'hFFFF_FFF8);
      recv("t2_blt", 0);
      send(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h8);
      recv("t2_bltu", 0);
      send(3'b111, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h8);
      recv("t2_bgeu", 0);
      send(3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h40, 32'h4);
      recv("t2_bge", 0);

      // 3: BNE not taken, target wraps.
      send(3'b001, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h20);
      recv("t3", 0);

      // 4: stalled consumer; input changes after accept and new requests are ignored.
      send(3'b001, 32'h5, 32'h6, 32'h1000, 32'h10);
      in_rs1 = 32'h6;
      recv("t4", 5);

      // 5: counter runs to all-ones, illegal keeps it, next taken wraps it.
      while (exp_cnt != '1) begin
         automatic logic [XLEN-1:0] v = $urandom;
         send(3'b000, v, v, $urandom, $urandom);
         recv("t5_fill", 0);
      end
      send(3'b010, 32'h1, 32'h1, 32'h300, 32'h4);
      recv("t5_ill010", 0);
      send(3'b011, 32'h1, 32'h2, 32'h300, 32'h4);
      recv("t5_ill011", 0);
      send(3'b000, 32'h7, 32'h7, 32'h300, 32'h4);
      recv("t5_wrap", 0);
      chk("t5_wrapped_zero", 64'(taken_count), 64'd0);

      // 6: reset in CALC aborts the operation and clears the counter.
      send(3'b000, 32'h9, 32'h9, 32'h500, 32'h4);
      recv("t6_pre", 0);
      send(3'b000, 32'h9, 32'h9, 32'h500, 32'h4);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb.delete();
      exp_cnt = '0;
      chk("t6_out_vld", 64'(out_valid),   64'd0);
      chk("t6_in_rdy",  64'(in_ready),    64'd1);
      chk("t6_count",   64'(taken_count), 64'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t6_no_stale", 64'(out_valid), 64'd0);
      end
      @(posedge clk); #1;
      send(3'b100, 32'h3, 32'hFFFF_FFFE, 32'h600, 32'h8);
      recv("t6_post", 0);
      chk("t6_sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
